// File: rtl/urv_timer_cmp_pkg.sv
// Shared definitions for the machine-timer compare unit: register map,
// CTRL bit positions and FSM state encodings.
package urv_timer_cmp_pkg;

  localparam logic [1:0] TIMER_CMP_LO = 2'd0;
  localparam logic [1:0] TIMER_CMP_HI = 2'd1;
  localparam logic [1:0] TIMER_CTRL   = 2'd2;
  localparam logic [1:0] TIMER_PERIOD = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_PENDING  = 2;
  localparam int CTRL_OVERRUN  = 3;
  localparam int CTRL_STATE_LO = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/urv_timer_cmp.sv
// Machine-timer compare unit: raises a level MTIP when the tick count reaches
// a programmable compare value, with one-shot and periodic auto-reload modes.
module urv_timer_cmp
  import urv_timer_cmp_pkg::*;
#(
  parameter int g_time_width   = 40,
  parameter int g_period_width = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_time_width-1:0] time_i,
  input  logic [1:0]              addr_i,
  input  logic [31:0]             wdata_i,
  input  logic                    we_i,
  input  logic                    re_i,
  output logic [31:0]             rdata_o,
  output logic                    irq_o
);

  localparam int HI_W = g_time_width - 32;

  tmr_state_e                state_q, state_d;
  logic [g_time_width-1:0]   cmp_q, cmp_d;
  logic [g_period_width-1:0] period_q, period_d;
  logic                      enable_q, enable_d;
  logic                      periodic_q, periodic_d;
  logic                      overrun_q, overrun_d;
  logic                      irq_q, irq_d;
  logic [31:0]               rdata_q, rdata_d;

  logic                      wr_lo, wr_hi, wr_ctrl, wr_period;
  logic                      w1c_pending, w1c_overrun;
  logic                      match, pending;
  logic [g_time_width-1:0]   period_ext, cmp_reload;
  logic [31:0]               period_rd, cmp_hi_rd;

  always_comb begin
    wr_lo       = we_i && (addr_i == TIMER_CMP_LO);
    wr_hi       = we_i && (addr_i == TIMER_CMP_HI);
    wr_ctrl     = we_i && (addr_i == TIMER_CTRL);
    wr_period   = we_i && (addr_i == TIMER_PERIOD);
    w1c_pending = wr_ctrl && wdata_i[CTRL_PENDING];
    w1c_overrun = wr_ctrl && wdata_i[CTRL_OVERRUN];
    pending     = (state_q == FIRED);
    match       = enable_q && (time_i >= cmp_q);

    // Reload wraps modulo 2^g_time_width on purpose; a wrapped compare value
    // is small, so the unit re-fires immediately.
    period_ext                     = '0;
    period_ext[g_period_width-1:0] = period_q;
    cmp_reload                     = cmp_q + period_ext;

    period_rd                      = '0;
    period_rd[g_period_width-1:0]  = period_q;
    cmp_hi_rd                      = '0;
    cmp_hi_rd[HI_W-1:0]            = cmp_q[g_time_width-1:32];
  end

  // Register file and FSM next state
  always_comb begin
    state_d    = state_q;
    cmp_d      = cmp_q;
    period_d   = period_q;
    enable_d   = enable_q;
    periodic_d = periodic_q;
    overrun_d  = overrun_q && !w1c_overrun;

    if (wr_lo)     cmp_d[31:0]              = wdata_i;
    if (wr_hi)     cmp_d[g_time_width-1:32] = wdata_i[HI_W-1:0];
    if (wr_period) period_d                 = wdata_i[g_period_width-1:0];
    if (wr_ctrl) begin
      enable_d   = wdata_i[CTRL_ENABLE];
      periodic_d = wdata_i[CTRL_PERIODIC];
    end

    // A compare-register write overrides any match or clear in the same cycle.
    if (wr_lo) begin
      state_d = IDLE;
    end else if (wr_hi) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (match) begin
            state_d = FIRED;
            if (periodic_q) cmp_d = cmp_reload;
          end
        end
        FIRED: begin
          if (w1c_pending) begin
            state_d = periodic_q ? ARMED : IDLE;
          end else if (periodic_q && match) begin
            overrun_d = 1'b1;
            cmp_d     = cmp_reload;
          end
        end
        default: state_d = state_q;
      endcase
    end

    irq_d = (state_d == FIRED);
  end

  // Read path, one cycle latency, holds between reads
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      unique case (addr_i)
        TIMER_CMP_LO: rdata_d = cmp_q[31:0];
        TIMER_CMP_HI: rdata_d = cmp_hi_rd;
        TIMER_CTRL:   rdata_d = {26'b0, state_q, overrun_q, pending,
                                 periodic_q, enable_q};
        default:      rdata_d = period_rd;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmp_q      <= '0;
      period_q   <= '0;
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      enable_q   <= enable_d;
      periodic_q <= periodic_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign irq_o   = irq_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_urv_timer_cmp.sv
// Self-checking bench for urv_timer_cmp: directed scenarios plus randomized
// traffic compared against a behavioural register/state model.
module tb_urv_timer_cmp;
  import urv_timer_cmp_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [39:0] time_i = '0;
  logic [1:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] rdata_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [39:0] WRAP_T = 40'hFF_FFFF_FFFE;

  urv_timer_cmp #(.g_time_width(40), .g_period_width(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .time_i(time_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .we_i(we_i), .re_i(re_i), .rdata_o(rdata_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: named registers and a state number 0/1/2
  logic [39:0] m_cmp;
  logic [31:0] m_period;
  bit          m_en, m_per, m_ovr, m_irq;
  int          m_state;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_cmp[31:0];
      2'd1:    return {24'b0, m_cmp[39:32]};
      2'd2:    return (m_state << 4) | (int'(m_ovr) << 3) |
                      (int'(m_state == 2) << 2) | (int'(m_per) << 1) | int'(m_en);
      default: return m_period;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit we, input bit re,
                            input logic [1:0] a, input logic [31:0] d,
                            input logic [39:0] t);
    bit          hit;
    logic [39:0] ncmp;
    logic [31:0] nper, nrd;
    bit          nen, nperiodic, novr;
    int          nstate;
    if (r) begin
      m_cmp = '0; m_period = '0; m_en = 0; m_per = 0; m_ovr = 0;
      m_state = 0; m_irq = 0; m_rdata = '0;
      return;
    end
    hit = m_en && (t >= m_cmp);
    ncmp = m_cmp; nper = m_period; nen = m_en; nperiodic = m_per;
    nstate = m_state; nrd = m_rdata;
    novr = m_ovr && !(we && a == 2'd2 && d[3]);
    if (re) nrd = m_read(a);
    if (we && a == 2'd0) ncmp[31:0] = d;
    if (we && a == 2'd1) ncmp[39:32] = d[7:0];
    if (we && a == 2'd2) begin nen = d[0]; nperiodic = d[1]; end
    if (we && a == 2'd3) nper = d;
    if (we && a == 2'd0)      nstate = 0;
    else if (we && a == 2'd1) nstate = 1;
    else if (m_state == 1 && hit) begin
      nstate = 2;
      if (m_per) ncmp = m_cmp + {8'b0, m_period};
    end else if (m_state == 2) begin
      if (we && a == 2'd2 && d[2]) nstate = m_per ? 1 : 0;
      else if (m_per && hit) begin
        novr = 1;
        ncmp = m_cmp + {8'b0, m_period};
      end
    end
    m_cmp = ncmp; m_period = nper; m_en = nen; m_per = nperiodic;
    m_ovr = novr; m_state = nstate; m_rdata = nrd; m_irq = (nstate == 2);
  endtask

  task automatic tick(input bit r, input bit we, input bit re,
                      input logic [1:0] a, input logic [31:0] d,
                      input logic [39:0] t);
    rst_i = r; we_i = we; re_i = re; addr_i = a; wdata_i = d; time_i = t;
    model_step(r, we, re, a, d, t);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 2'd0, 0, 0);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%0b want=0", irq_o); end
    n_cmp++;
    if (rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%08h want=0", rdata_o); end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 2'(i), 0, 0);
      n_cmp++;
      if (rdata_o !== 32'h0) begin
        n_err++; $display("FAIL reset_read[%0d] got=%08h want=00000000", i, rdata_o);
      end
    end
  endtask

  task automatic test_one_shot();
    tick(1, 0, 0, 2'd0, 0, 98);
    tick(0, 1, 0, TIMER_CMP_LO, 100, 98);
    tick(0, 1, 0, TIMER_CMP_HI, 0, 98);
    tick(0, 1, 0, TIMER_CTRL, 1, 98);
    tick(0, 0, 0, 2'd0, 0, 99);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL oneshot_early got=%0b want=0", irq_o); end
    tick(0, 0, 0, 2'd0, 0, 100);
    n_cmp++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL oneshot_fire got=%0b want=1", irq_o); end
    tick(0, 1, 0, TIMER_CTRL, 5, 101);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL oneshot_clear got=%0b want=0", irq_o); end
    tick(0, 0, 1, TIMER_CTRL, 0, 102);
    n_cmp++;
    if (rdata_o !== 32'h1) begin n_err++; $display("FAIL oneshot_ctrl got=%08h want=00000001", rdata_o); end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 2'd0, 0, 200);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL oneshot_refire got=%0b want=0", irq_o); end
  endtask

  task automatic test_periodic();
    tick(1, 0, 0, 2'd0, 0, 0);
    tick(0, 1, 0, TIMER_CMP_LO, 10, 0);
    tick(0, 1, 0, TIMER_CMP_HI, 0, 0);
    tick(0, 1, 0, TIMER_PERIOD, 5, 0);
    tick(0, 1, 0, TIMER_CTRL, 3, 0);
    tick(0, 0, 0, 2'd0, 0, 8);
    tick(0, 0, 0, 2'd0, 0, 9);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL per_early got=%0b want=0", irq_o); end
    tick(0, 0, 0, 2'd0, 0, 10);
    n_cmp++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL per_fire1 got=%0b want=1", irq_o); end
    tick(0, 0, 1, TIMER_CMP_LO, 0, 11);
    n_cmp++;
    if (rdata_o !== 32'd15) begin n_err++; $display("FAIL per_cmp15 got=%0d want=15", rdata_o); end
    tick(0, 1, 0, TIMER_CTRL, 7, 12);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL per_w1c got=%0b want=0", irq_o); end
    tick(0, 0, 0, 2'd0, 0, 13);
    tick(0, 0, 0, 2'd0, 0, 14);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL per_wait got=%0b want=0", irq_o); end
    tick(0, 0, 0, 2'd0, 0, 15);
    n_cmp++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL per_fire2 got=%0b want=1", irq_o); end
    tick(0, 0, 1, TIMER_CMP_LO, 0, 16);
    n_cmp++;
    if (rdata_o !== 32'd20) begin n_err++; $display("FAIL per_cmp20 got=%0d want=20", rdata_o); end
    for (int t = 17; t <= 20; t++) tick(0, 0, 0, 2'd0, 0, 40'(t));
    tick(0, 0, 1, TIMER_CTRL, 0, 21);
    n_cmp++;
    if (rdata_o !== 32'h2F) begin n_err++; $display("FAIL per_overrun got=%08h want=0000002f", rdata_o); end
    tick(0, 0, 1, TIMER_CMP_LO, 0, 22);
    n_cmp++;
    if (rdata_o !== 32'd25) begin n_err++; $display("FAIL per_cmp25 got=%0d want=25", rdata_o); end
  endtask

  task automatic test_back_to_back();
    tick(1, 0, 0, 2'd0, 0, 40);
    tick(0, 1, 0, TIMER_CMP_LO, 50, 40);
    tick(0, 1, 0, TIMER_CMP_HI, 0, 40);
    tick(0, 1, 0, TIMER_PERIOD, 5, 40);
    tick(0, 1, 0, TIMER_CTRL, 3, 40);
    tick(0, 0, 0, 2'd0, 0, 49);
    tick(0, 1, 0, TIMER_CTRL, 7, 50);
    n_cmp++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL race_irq got=%0b want=1", irq_o); end
    tick(0, 0, 1, TIMER_CTRL, 0, 51);
    n_cmp++;
    if (rdata_o !== 32'h27) begin n_err++; $display("FAIL race_ctrl got=%08h want=00000027", rdata_o); end
  endtask

  task automatic test_wrap_and_disarm();
    tick(1, 0, 0, 2'd0, 0, 0);
    tick(0, 1, 0, TIMER_CMP_LO, 32'hFFFF_FFFE, 0);
    tick(0, 1, 0, TIMER_CMP_HI, 32'hFF, 0);
    tick(0, 1, 0, TIMER_PERIOD, 4, 0);
    tick(0, 1, 0, TIMER_CTRL, 3, 0);
    tick(0, 0, 0, 2'd0, 0, WRAP_T);
    n_cmp++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL wrap_fire got=%0b want=1", irq_o); end
    tick(0, 0, 1, TIMER_CMP_LO, 0, WRAP_T);
    n_cmp++;
    if (rdata_o !== 32'd2) begin n_err++; $display("FAIL wrap_cmp_lo got=%08h want=00000002", rdata_o); end
    tick(0, 0, 1, TIMER_CMP_HI, 0, WRAP_T);
    n_cmp++;
    if (rdata_o !== 32'd0) begin n_err++; $display("FAIL wrap_cmp_hi got=%08h want=00000000", rdata_o); end
    tick(0, 0, 1, TIMER_CTRL, 0, WRAP_T);
    n_cmp++;
    if (rdata_o !== 32'h2F) begin n_err++; $display("FAIL wrap_overrun got=%08h want=0000002f", rdata_o); end
    tick(0, 1, 0, TIMER_CMP_LO, 0, WRAP_T);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL disarm got=%0b want=0", irq_o); end
    tick(0, 1, 0, TIMER_CMP_HI, 0, WRAP_T);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL arm_delay got=%0b want=0", irq_o); end
    tick(0, 0, 0, 2'd0, 0, WRAP_T);
    n_cmp++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL arm_fire got=%0b want=1", irq_o); end
    tick(1, 0, 0, 2'd0, 0, WRAP_T);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL rst_fired got=%0b want=0", irq_o); end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 2'(i), 0, WRAP_T);
      n_cmp++;
      if (rdata_o !== 32'h0 || irq_o !== 1'b0) begin
        n_err++; $display("FAIL rst_read[%0d] got=%08h irq=%0b want=00000000 irq=0", i, rdata_o, irq_o);
      end
    end
  endtask

  task automatic test_random();
    logic [39:0] t;
    logic [31:0] d;
    logic [1:0]  a;
    bit          r, we, re;
    int          op;
    t = 40'd1000;
    tick(1, 0, 0, 2'd0, 0, t);
    for (int c = 0; c < 600; c++) begin
      t = t + 40'($urandom_range(0, 2));
      r = ($urandom_range(0, 199) == 0);
      we = 0; re = 0; a = 2'd0; d = '0;
      op = $urandom_range(0, 11);
      case (op)
        0: begin we = 1; a = TIMER_CMP_LO; d = t[31:0] + $urandom_range(0, 30); end
        1: begin we = 1; a = TIMER_CMP_HI;
                 d = ($urandom_range(0, 7) == 0) ? $urandom : {24'b0, t[39:32]}; end
        2: begin we = 1; a = TIMER_CTRL; d = $urandom_range(0, 15); end
        3: begin we = 1; a = TIMER_PERIOD; d = $urandom_range(0, 12); end
        4, 5, 6: begin re = 1; a = 2'($urandom_range(0, 3)); end
        default: ;
      endcase
      tick(r, we, re, a, d, t);
      n_cmp++;
      if (irq_o !== m_irq) begin
        n_err++; $display("FAIL rand_irq cyc=%0d got=%0b want=%0b", c, irq_o, m_irq);
      end
      n_cmp++;
      if (rdata_o !== m_rdata) begin
        n_err++; $display("FAIL rand_rdata cyc=%0d got=%08h want=%08h", c, rdata_o, m_rdata);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_back_to_back();
    test_wrap_and_disarm();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
